instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of a synchronous instruction ROM. It drives the ROM
// byte address, captures the word returned one cycle later and pairs it with
// the PC it was fetched from. It then hands {pc, instr} to decode over a
// valid/ready interface. One request may be in flight, and responses land in
// a 2-entry FIFO. This sustains one instruction per cycle while tolerating
// back-pressure. A redirect flushes everything and restarts at a new PC.
//
// Parameters
//   ROM_ADDR_W      byte-address width of the ROM port
//   RESET_PC        first PC fetched after reset (word aligned)
//
// Ports
//   clk             clock
//   reset_n         synchronous, active-low reset
//   rom_addr        byte address to ROM (ROM registers it on posedge clk)
//   rom_data        ROM word for the address presented in the previous cycle
//   fetch_en        permits new fetches; low only stalls issue
//   redirect_valid  one-cycle pulse: flush and restart fetch at redirect_pc
//   redirect_pc     redirect target; bits [1:0] are forced to zero
//   out_valid       out_instr/out_pc hold a valid instruction
//   out_ready       decode accepts the instruction this cycle
//   out_instr       instruction word (FIFO head)
//   out_pc          byte PC of out_instr (FIFO head)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int          ROM_ADDR_W = 16,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [31:0]           rom_data,
   input  logic                  fetch_en,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [31:0]           out_pc
);

   // Fetch state
   logic [31:0] fetch_pc_reg;
   logic [31:0] fetch_pc_next;
   logic        inflight_reg;
   logic [31:0] issued_pc_reg;

   // Response FIFO: slot 0 is always the head, so the outputs come
   // straight from registers and stay put while decode stalls.
   logic [31:0] fifo_pc_reg    [2];
   logic [31:0] fifo_instr_reg [2];
   logic [1:0]  count_reg;

   logic [31:0] redirect_pc_aligned;
   logic [31:0] addr_full;
   logic [2:0]  occupancy;
   logic        pop;
   logic        push;
   logic        issue;
   logic        start_request;

   assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

   // The handshake in a redirect cycle is void because decode is flushing
   // too. Masking valid keeps the pop from disturbing the flush.
   assign out_valid = (count_reg != 2'd0) & ~redirect_valid;
   assign out_pc    = fifo_pc_reg[0];
   assign out_instr = fifo_instr_reg[0];

   assign pop  = out_valid & out_ready;
   // The response to a request issued before a redirect is dropped.
   assign push = inflight_reg & ~redirect_valid;

   // Buffered entries plus the pending response. A pop in the same cycle
   // frees a slot for the response that this cycle's issue will return.
   // The sum never exceeds 2, so the FIFO cannot overflow.
   assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
   assign issue     = fetch_en & ~redirect_valid & ((occupancy < 3'd2) | pop);

   // A redirect with fetch_en high fetches the target in the same cycle.
   assign start_request = issue | (redirect_valid & fetch_en);

   // The ROM always reads rom_addr. Cycles that do not issue simply ignore
   // the returned word.
   always_comb begin
      addr_full = fetch_pc_reg;
      if (!reset_n) begin
         addr_full = RESET_PC;
      end else if (redirect_valid) begin
         addr_full = redirect_pc_aligned;
      end
      rom_addr = addr_full[ROM_ADDR_W-1:0];
   end

   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      if (redirect_valid) begin
         fetch_pc_next = fetch_en ? (redirect_pc_aligned + 32'd4) : redirect_pc_aligned;
      end else if (issue) begin
         fetch_pc_next = fetch_pc_reg + 32'd4;   // wraps naturally at 2^32
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc_reg      <= RESET_PC;
         inflight_reg      <= 1'b0;
         issued_pc_reg     <= 32'd0;
         count_reg         <= 2'd0;
         fifo_pc_reg[0]    <= 32'd0;
         fifo_pc_reg[1]    <= 32'd0;
         fifo_instr_reg[0] <= 32'd0;
         fifo_instr_reg[1] <= 32'd0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         inflight_reg <= start_request;
         if (start_request) begin
            issued_pc_reg <= redirect_valid ? redirect_pc_aligned : fetch_pc_reg;
         end

         if (redirect_valid) begin
            count_reg <= 2'd0;
         end else begin
            unique case ({push, pop})
               2'b10: begin
                  if (count_reg == 2'd0) begin
                     fifo_pc_reg[0]    <= issued_pc_reg;
                     fifo_instr_reg[0] <= rom_data;
                  end else begin
                     fifo_pc_reg[1]    <= issued_pc_reg;
                     fifo_instr_reg[1] <= rom_data;
                  end
                  count_reg <= count_reg + 2'd1;
               end
               2'b01: begin
                  fifo_pc_reg[0]    <= fifo_pc_reg[1];
                  fifo_instr_reg[0] <= fifo_instr_reg[1];
                  count_reg         <= count_reg - 2'd1;
               end
               2'b11: begin
                  // Count stays the same. The new entry goes behind
                  // whatever remains after the pop.
                  if (count_reg == 2'd1) begin
                     fifo_pc_reg[0]    <= issued_pc_reg;
                     fifo_instr_reg[0] <= rom_data;
                  end else begin
                     fifo_pc_reg[0]    <= fifo_pc_reg[1];
                     fifo_instr_reg[0] <= fifo_instr_reg[1];
                     fifo_pc_reg[1]    <= issued_pc_reg;
                     fifo_instr_reg[1] <= rom_data;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] rom_addr;
   logic [31:0] rom_data;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.ROM_ADDR_W(16), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   // ROM model: word i = 0x1000_0000 + i, address registered on posedge.
   logic [13:0] rom_q = 14'd0;
   always @(posedge clk) rom_q <= rom_addr[15:2];
   assign rom_data = 32'h1000_0000 + {18'd0, rom_q};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One cycle: advance to just after the edge, apply this cycle's inputs,
   // then check the outputs for this cycle.
   task automatic cyc(input string tag, input logic rst_n, input logic fe, input logic rdy,
                      input logic rv, input logic [31:0] rpc,
                      input logic exp_v, input logic [31:0] exp_pc);
      @(posedge clk);
      #1;
      reset_n        = rst_n;
      fetch_en       = fe;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_v) begin
         chk({tag, ".pc"}, out_pc, exp_pc);
         chk({tag, ".instr"}, out_instr, 32'h1000_0000 + (exp_pc >> 2));
      end
      $display("[TB] %s rst_n=%0b fe=%0b rdy=%0b rv=%0b valid=%0b pc=%h instr=%h",
               tag, rst_n, fe, rdy, rv, out_valid, out_pc, out_instr);
   endtask

   initial begin
      reset_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'd0;

      // Reset state
      cyc("rst0", 0, 1, 1, 0, 0, 0, 0);
      cyc("rst1", 0, 1, 1, 0, 0, 0, 0);
      chk("rst.rom_addr", {16'd0, rom_addr}, 32'h0);
      chk("rst.out_pc", out_pc, 32'h0);
      chk("rst.out_instr", out_instr, 32'h0);

      // Release: cycle 0, first output in cycle 2, gapless stream
      cyc("c0", 1, 1, 1, 0, 0, 0, 0);
      chk("c0.rom_addr", {16'd0, rom_addr}, 32'h0);
      cyc("c1", 1, 1, 1, 0, 0, 0, 0);
      chk("c1.rom_addr", {16'd0, rom_addr}, 32'h4);
      cyc("c2", 1, 1, 1, 0, 0, 1, 32'h00);
      cyc("c3", 1, 1, 1, 0, 0, 1, 32'h04);
      cyc("c4", 1, 1, 1, 0, 0, 1, 32'h08);
      cyc("c5", 1, 1, 1, 0, 0, 1, 32'h0C);
      cyc("c6", 1, 1, 1, 0, 0, 1, 32'h10);

      // Back-pressure for 5 cycles: head frozen, then resume without skip
      cyc("bp7",  1, 1, 0, 0, 0, 1, 32'h14);
      cyc("bp8",  1, 1, 0, 0, 0, 1, 32'h14);
      cyc("bp9",  1, 1, 0, 0, 0, 1, 32'h14);
      cyc("bp10", 1, 1, 0, 0, 0, 1, 32'h14);
      cyc("bp11", 1, 1, 0, 0, 0, 1, 32'h14);
      cyc("c12", 1, 1, 1, 0, 0, 1, 32'h14);
      cyc("c13", 1, 1, 1, 0, 0, 1, 32'h18);
      cyc("c14", 1, 1, 1, 0, 0, 1, 32'h1C);
      cyc("c15", 1, 1, 1, 0, 0, 1, 32'h20);

      // Fill both slots, then redirect to 0x40
      cyc("c16", 1, 1, 0, 0, 0, 1, 32'h24);
      cyc("rd17", 1, 1, 1, 1, 32'h40, 0, 0);
      chk("rd17.rom_addr", {16'd0, rom_addr}, 32'h40);
      cyc("c18", 1, 1, 1, 0, 0, 0, 0);
      cyc("c19", 1, 1, 1, 0, 0, 1, 32'h40);
      cyc("c20", 1, 1, 1, 0, 0, 1, 32'h44);
      cyc("c21", 1, 1, 1, 0, 0, 1, 32'h48);

      // Unaligned redirect target 0x43 with fetch_en = 1
      cyc("rd22", 1, 1, 1, 1, 32'h43, 0, 0);
      chk("rd22.rom_addr", {16'd0, rom_addr}, 32'h40);
      cyc("c23", 1, 1, 1, 0, 0, 0, 0);
      cyc("c24", 1, 1, 1, 0, 0, 1, 32'h40);
      cyc("c25", 1, 1, 1, 0, 0, 1, 32'h44);

      // Same redirect with fetch_en = 0: nothing until fetch_en rises
      cyc("rd26", 1, 0, 1, 1, 32'h43, 0, 0);
      cyc("c27", 1, 0, 1, 0, 0, 0, 0);
      cyc("c28", 1, 0, 1, 0, 0, 0, 0);
      cyc("c29", 1, 1, 1, 0, 0, 0, 0);
      chk("c29.rom_addr", {16'd0, rom_addr}, 32'h40);
      cyc("c30", 1, 1, 1, 0, 0, 0, 0);
      cyc("c31", 1, 1, 1, 0, 0, 1, 32'h40);

      // fetch_en low for 3 cycles: drain buffered and in-flight only
      cyc("fe32", 1, 0, 1, 0, 0, 1, 32'h44);
      cyc("fe33", 1, 0, 1, 0, 0, 1, 32'h48);
      cyc("fe34", 1, 0, 1, 0, 0, 0, 0);
      cyc("c35", 1, 1, 1, 0, 0, 0, 0);
      cyc("c36", 1, 1, 1, 0, 0, 0, 0);
      cyc("c37", 1, 1, 1, 0, 0, 1, 32'h4C);
      cyc("c38", 1, 1, 1, 0, 0, 1, 32'h50);

      // Reset mid-stream with 2 buffered
      cyc("c39", 1, 1, 0, 0, 0, 1, 32'h54);
      cyc("c40", 1, 1, 0, 0, 0, 1, 32'h54);
      cyc("rs41", 0, 1, 1, 0, 0, 1, 32'h54);
      chk("rs41.rom_addr", {16'd0, rom_addr}, 32'h0);
      cyc("r0", 1, 1, 1, 0, 0, 0, 0);
      chk("r0.out_pc", out_pc, 32'h0);
      chk("r0.out_instr", out_instr, 32'h0);
      cyc("r1", 1, 1, 1, 0, 0, 0, 0);
      cyc("r2", 1, 1, 1, 0, 0, 1, 32'h00);
      cyc("r3", 1, 1, 1, 0, 0, 1, 32'h04);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
